// File: rtl/ccd_readout_sequencer.sv
// rtl/ccd_readout_sequencer.sv - linear CCD frame sequencer (transfer gate, shift and reset clocks)
// Optional ADC sample strobe (pix_valid/pix_index) built only with CCD_SEQ_PIXSTROBE_EN defined.
module ccd_readout_sequencer #(
    parameter int          QUARTER_CYC = 4,
    parameter int          N_PIXELS    = 3694,
    parameter int          PHI_P_CYC   = 16,
    parameter logic [31:0] MIN_EXP     = 32'h186A00,
    parameter logic [15:0] EXP_STEP    = 16'h6429
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  f_select,
    output logic        phi_p,
    output logic        phi_l2,
    output logic        phi_l1,
    output logic        phi_r,
    output logic        frame_start,
    output logic        busy,
    output logic        overrun,
    output logic        pix_valid,
    output logic [11:0] pix_index
);

    localparam int Q_W = (QUARTER_CYC > 1) ? $clog2(QUARTER_CYC) : 1;
    localparam int T_W = (PHI_P_CYC > 1) ? $clog2(PHI_P_CYC) : 1;
    localparam logic [Q_W-1:0] Q_LAST   = Q_W'(QUARTER_CYC - 1);
    localparam logic [T_W-1:0] T_LAST   = T_W'(PHI_P_CYC - 1);
    localparam logic [11:0]    PIX_LAST = 12'(N_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRANSFER = 2'd1,
        S_READOUT  = 2'd2,
        S_WAIT     = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [T_W-1:0] t_cnt, t_n;
    logic [Q_W-1:0] q_cnt, q_n;
    logic [1:0]     qi, qi_n;
    logic [11:0]    pix_cnt, pix_n;
    logic [31:0]    exp_cnt, exp_n;
    logic [7:0]     f_sel, f_sel_n;
    logic [31:0]    exp_target;
    logic           exp_hit;
    logic           ro_last;
    logic           frame_entry;
    logic           set_ovr;

    // Next-state, counter and exposure bookkeeping; outputs are registered from these next values
    always_comb begin
        state_n    = state;
        set_ovr    = 1'b0;
        exp_target = MIN_EXP + 32'(f_sel) * 32'(EXP_STEP);
        exp_hit    = (exp_cnt >= exp_target - 32'd1);
        ro_last    = (q_cnt == Q_LAST) && (qi == 2'd3) && (pix_cnt == PIX_LAST);

        case (state)
            S_IDLE: begin
                if (enable) state_n = S_TRANSFER;
            end
            S_TRANSFER: begin
                if (t_cnt == T_LAST) state_n = S_READOUT;
            end
            S_READOUT: begin
                if (ro_last) begin
                    // enable is only honoured here and at the end of WAIT (frame boundaries)
                    if (exp_hit) begin
                        set_ovr = 1'b1;
                        state_n = enable ? S_TRANSFER : S_IDLE;
                    end else begin
                        state_n = enable ? S_WAIT : S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (exp_hit) state_n = enable ? S_TRANSFER : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        frame_entry = (state_n == S_TRANSFER) && (state != S_TRANSFER);

        t_n = (state == S_TRANSFER && state_n == S_TRANSFER) ? t_cnt + 1'b1 : '0;

        // Readout position restarts at zero on entry, advances while READOUT continues
        q_n   = '0;
        qi_n  = '0;
        pix_n = '0;
        if (state == S_READOUT && state_n == S_READOUT) begin
            q_n   = q_cnt + 1'b1;
            qi_n  = qi;
            pix_n = pix_cnt;
            if (q_cnt == Q_LAST) begin
                q_n  = '0;
                qi_n = qi + 2'd1;
                if (qi == 2'd3) pix_n = pix_cnt + 12'd1;
            end
        end

        // Exposure count starts at 0 on the first TRANSFER cycle and saturates
        if (frame_entry)
            exp_n = '0;
        else if (state != S_IDLE && exp_cnt != 32'hFFFF_FFFF)
            exp_n = exp_cnt + 32'd1;
        else
            exp_n = exp_cnt;

        f_sel_n = frame_entry ? f_select : f_sel;
    end

    // State, counters and registered clock outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            t_cnt       <= '0;
            q_cnt       <= '0;
            qi          <= '0;
            pix_cnt     <= '0;
            exp_cnt     <= '0;
            f_sel       <= '0;
            phi_p       <= 1'b0;
            phi_l2      <= 1'b0;
            phi_l1      <= 1'b0;
            phi_r       <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            t_cnt       <= t_n;
            q_cnt       <= q_n;
            qi          <= qi_n;
            pix_cnt     <= pix_n;
            exp_cnt     <= exp_n;
            f_sel       <= f_sel_n;
            phi_p       <= (state_n == S_TRANSFER);
            phi_l2      <= (state_n == S_READOUT) && (qi_n < 2'd2);
            phi_l1      <= (state_n == S_READOUT) && (qi_n >= 2'd2);
            phi_r       <= (state_n == S_READOUT) && (qi_n == 2'd0);
            frame_start <= frame_entry;
            busy        <= (state_n != S_IDLE);
            overrun     <= overrun | set_ovr;
        end
    end

`ifdef CCD_SEQ_PIXSTROBE_EN
    // ADC strobe in the last clk of quarter 2 of every pixel, tagged with that pixel's index
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_index <= '0;
        end else begin
            pix_valid <= (state_n == S_READOUT) && (qi_n == 2'd2) && (q_n == Q_LAST);
            if ((state_n == S_READOUT) && (qi_n == 2'd2) && (q_n == Q_LAST))
                pix_index <= pix_n;
        end
    end
`else
    assign pix_valid = 1'b0;
    assign pix_index = '0;
`endif

endmodule
